// File: rtl/spi_block_tx_pkg.sv
// Shared SPI definitions: controller state encoding, default word width and
// the mode-0 clocking convention used by the transmit and receive blocks.
package spi_block_tx_pkg;

  localparam int unsigned SPI_DATA_WIDTH_DEFAULT = 32;

  // Mode 0: dclk idles low, data launched on falling edges, sampled on rising.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } spi_state_e;

  function automatic int unsigned spi_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_block_tx_evt_counter.sv
// Wrapping event counter: counts evt_in pulses modulo MAX_COUNT.
module evt_counter
  import spi_block_tx_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 128,
  parameter int unsigned COUNT_W   = spi_cnt_width(MAX_COUNT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               evt_in,
  output logic [COUNT_W-1:0] count_out
);

  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(MAX_COUNT - 1);

  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count_q <= '0;
    end else if (evt_in) begin
      count_q <= (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/spi_block_tx.sv
// Mode-0 SPI word transmitter with per-frame block counting.
// Define SPI_BLOCK_TX_CAPTURE_EN to also capture chip_data_in into data_out.
module spi_block_tx
  import spi_block_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = SPI_DATA_WIDTH_DEFAULT,
  parameter int unsigned DATA_CLK_PERIOD = 100,
  parameter int unsigned NUM_BLOCKS      = 128
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
`ifdef SPI_BLOCK_TX_CAPTURE_EN
  input  logic                  chip_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
`endif
  output logic                  ready_out,
  output logic                  chip_data_out,
  output logic                  chip_clk_out,
  output logic                  chip_sel_out,
  output logic                  done_out,
  output logic                  final_out
);

  localparam int unsigned PW = spi_cnt_width(DATA_CLK_PERIOD);
  localparam int unsigned BW = spi_cnt_width(DATA_WIDTH);
  localparam int unsigned FW = spi_cnt_width(NUM_BLOCKS);

  localparam logic [PW-1:0] PHASE_RISE = PW'(DATA_CLK_PERIOD / 2 - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DATA_CLK_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_BLOCKS - 1);

  generate
    if ((DATA_CLK_PERIOD < 2) || ((DATA_CLK_PERIOD % 2) != 0)) begin : g_bad_period
      $error("spi_block_tx: DATA_CLK_PERIOD must be even and at least 2");
    end
  endgenerate

  spi_state_e            state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [PW-1:0]         phase_q;
  logic [BW-1:0]         bit_q;
  logic                  cs_q;
  logic                  clk_q;
  logic                  done_q;
  logic                  final_q;
  logic [FW-1:0]         frame_cnt;
`ifdef SPI_BLOCK_TX_CAPTURE_EN
  logic [DATA_WIDTH-1:0] cap_q;
  logic [DATA_WIDTH-1:0] data_out_q;
`endif

  // The shift register MSB drives COPI directly; it is cleared whenever the
  // word ends so the line rests low while chip select is high.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      shreg_q <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      clk_q   <= 1'b0;
      done_q  <= 1'b0;
      final_q <= 1'b0;
`ifdef SPI_BLOCK_TX_CAPTURE_EN
      cap_q      <= '0;
      data_out_q <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      final_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            state_q <= SHIFT;
            shreg_q <= data_in;
            cs_q    <= 1'b0;
            clk_q   <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
          end
        end
        SHIFT: begin
          phase_q <= phase_q + 1'b1;
          if (phase_q == PHASE_RISE) begin
            clk_q <= 1'b1;
`ifdef SPI_BLOCK_TX_CAPTURE_EN
            cap_q <= {cap_q[DATA_WIDTH-2:0], chip_data_in};
`endif
          end
          if (phase_q == PHASE_LAST) begin
            clk_q   <= 1'b0;
            phase_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= GAP;
              cs_q    <= 1'b1;
              shreg_q <= '0;
              done_q  <= 1'b1;
              final_q <= (frame_cnt == FRAME_LAST);
`ifdef SPI_BLOCK_TX_CAPTURE_EN
              data_out_q <= cap_q;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        GAP: begin
          phase_q <= phase_q + 1'b1;
          if (phase_q == PHASE_LAST) begin
            phase_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counter advances the cycle after done, so final sees the pre-increment count.
  evt_counter #(
    .MAX_COUNT (NUM_BLOCKS),
    .COUNT_W   (FW)
  ) u_frame_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .evt_in    (done_q),
    .count_out (frame_cnt)
  );

  assign ready_out     = (state_q == IDLE);
  assign chip_data_out = shreg_q[DATA_WIDTH-1];
  assign chip_clk_out  = clk_q;
  assign chip_sel_out  = cs_q;
  assign done_out      = done_q;
  assign final_out     = final_q;
`ifdef SPI_BLOCK_TX_CAPTURE_EN
  assign data_out = data_out_q;
`endif

endmodule
